// File: rtl/regfile_mp.sv
// Two-read / two-write integer register file with per-register busy scoreboard and stall hold.
// Define REGFILE_BYPASS_EN to forward same-edge writes and busy updates to the read outputs.
module regfile_mp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rd_en,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  output logic [XLEN-1:0]          a,
  output logic [XLEN-1:0]          b,
  output logic                     a_busy,
  output logic                     b_busy,
  input  logic                     we0,
  input  logic [$clog2(NREGS)-1:0] wa0,
  input  logic [XLEN-1:0]          wd0,
  input  logic                     we1,
  input  logic [$clog2(NREGS)-1:0] wa1,
  input  logic [XLEN-1:0]          wd1,
  input  logic                     set_busy,
  input  logic [$clog2(NREGS)-1:0] set_addr,
  output logic [NREGS-1:0]         busy
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic             a_busy_q, a_busy_d, b_busy_q, b_busy_d;

  // Port 1 is applied last so a load wins a same-address conflict.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we0 && (wa0 != AW'(0))) regs_d[wa0] = wd0;
    if (we1 && (wa1 != AW'(0))) regs_d[wa1] = wd1;
    regs_d[0] = '0;
  end

  // Set is applied after clear: a newly issued producer outranks a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (we0) busy_d[wa0] = 1'b0;
    if (we1) busy_d[wa1] = 1'b0;
    if (set_busy) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    a_busy_d = a_busy_q;
    b_busy_d = b_busy_q;
    if (rd_en) begin
`ifdef REGFILE_BYPASS_EN
      a_d      = regs_d[rs1];
      b_d      = regs_d[rs2];
      a_busy_d = busy_d[rs1];
      b_busy_d = busy_d[rs2];
`else
      a_d      = regs_q[rs1];
      b_d      = regs_q[rs2];
      a_busy_d = busy_q[rs1];
      b_busy_d = busy_q[rs2];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_busy_q <= 1'b0;
      b_busy_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q   <= busy_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_busy_q <= a_busy_d;
      b_busy_q <= b_busy_d;
    end
  end

  assign a      = a_q;
  assign b      = b_q;
  assign a_busy = a_busy_q;
  assign b_busy = b_busy_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expectations are queued as stimulus is driven and
// checked after each edge (or immediately, for asynchronous reset).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        rd_en = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic [31:0] a, b;
  logic        a_busy, b_busy;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic        set_busy = 1'b0;
  logic [4:0]  set_addr = '0;
  logic [31:0] busy;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  regfile_mp #(.XLEN(32), .NREGS(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_en    (rd_en),
    .rs1      (rs1),
    .rs2      (rs2),
    .a        (a),
    .b        (b),
    .a_busy   (a_busy),
    .b_busy   (b_busy),
    .we0      (we0),
    .wa0      (wa0),
    .wd0      (wd0),
    .we1      (we1),
    .wa1      (wa1),
    .wd1      (wd1),
    .set_busy (set_busy),
    .set_addr (set_addr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef enum int {SelA, SelB, SelABusy, SelBBusy, SelBusy} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] observe(sel_e sel);
    case (sel)
      SelA:     return a;
      SelB:     return b;
      SelABusy: return {31'd0, a_busy};
      SelBBusy: return {31'd0, b_busy};
      default:  return busy;
    endcase
  endfunction

  task automatic expect_out(string tag, sel_e sel, logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = val;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_assert++;
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    // Reset held, then released
    #2 reset_n = 1'b0;
    expect_out("rst_a", SelA, 32'h0);
    expect_out("rst_b", SelB, 32'h0);
    expect_out("rst_busy", SelBusy, 32'h0);
    #1 check_now();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd_en = 1'b1; rs1 = 5'd5; rs2 = 5'd31;
    expect_out("post_rst_a", SelA, 32'h0);
    expect_out("post_rst_b", SelB, 32'h0);
    expect_out("post_rst_busy", SelBusy, 32'h0);
    expect_out("post_rst_abusy", SelABusy, 32'h0);
    tick();

    // Write then read
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; rs1 = 5'd5;
    expect_out("wr5_same_edge", SelA, Byp ? 32'hDEADBEEF : 32'h0);
    tick();
    we0 = 1'b0;
    expect_out("wr5_read", SelA, 32'hDEADBEEF);
    tick();

    // Write to x0 is dropped
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1234; rs2 = 5'd0;
    expect_out("x0_same_edge", SelB, 32'h0);
    tick();
    we1 = 1'b0;
    expect_out("x0_read", SelB, 32'h0);
    tick();

    // Dual-write conflict: port 1 wins
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    tick();
    we0 = 1'b0; we1 = 1'b0; rs1 = 5'd7;
    expect_out("conflict_r7", SelA, 32'h22);
    tick();
    we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    tick();
    we0 = 1'b0; we1 = 1'b0; rs1 = 5'd7; rs2 = 5'd8;
    expect_out("dual_r7", SelA, 32'h22);
    expect_out("dual_r8", SelB, 32'h11);
    tick();

    // Write-to-read through the same edge
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hA5A5A5A5; rs1 = 5'd9;
    expect_out("byp_same_edge", SelA, Byp ? 32'hA5A5A5A5 : 32'h0);
    tick();
    we1 = 1'b0;
    expect_out("byp_next", SelA, 32'hA5A5A5A5);
    tick();

    // Scoreboard
    set_busy = 1'b1; set_addr = 5'd3; rs1 = 5'd3;
    expect_out("sb_set_busy", SelBusy, 32'h8);
    expect_out("sb_set_abusy", SelABusy, Byp ? 32'h1 : 32'h0);
    tick();
    set_busy = 1'b0;
    expect_out("sb_hold_abusy", SelABusy, 32'h1);
    expect_out("sb_hold_busy", SelBusy, 32'h8);
    tick();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h3;
    expect_out("sb_clr_busy", SelBusy, 32'h0);
    expect_out("sb_clr_abusy", SelABusy, Byp ? 32'h0 : 32'h1);
    tick();
    we0 = 1'b0;
    expect_out("sb_clr_abusy2", SelABusy, 32'h0);
    tick();
    set_busy = 1'b1; set_addr = 5'd3;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h33;
    expect_out("sb_set_wins", SelBusy, 32'h8);
    tick();
    we1 = 1'b0; set_addr = 5'd0; rs2 = 5'd3;
    expect_out("sb_x0_ignored", SelBusy, 32'h8);
    expect_out("sb_bbusy", SelBBusy, 32'h1);
    tick();
    set_busy = 1'b0; rs1 = 5'd3;
    expect_out("sb_r3_data", SelA, 32'h33);
    tick();

    // Stall
    rs1 = 5'd5;
    expect_out("stall_latch", SelA, 32'hDEADBEEF);
    tick();
    rd_en = 1'b0; rs1 = 5'd9;
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h55;
    expect_out("stall_hold1", SelA, 32'hDEADBEEF);
    expect_out("stall_hold_bbusy", SelBBusy, 32'h1);
    tick();
    we0 = 1'b0;
    expect_out("stall_hold2", SelA, 32'hDEADBEEF);
    tick();
    rd_en = 1'b1; rs1 = 5'd5;
    expect_out("stall_release", SelA, 32'h55);
    tick();

    // Mid-cycle asynchronous reset
    #2 reset_n = 1'b0;
    expect_out("mid_rst_a", SelA, 32'h0);
    expect_out("mid_rst_b", SelB, 32'h0);
    expect_out("mid_rst_busy", SelBusy, 32'h0);
    expect_out("mid_rst_bbusy", SelBBusy, 32'h0);
    #1 check_now();
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h77;
    set_busy = 1'b1; set_addr = 5'd10;
    expect_out("rst_no_commit_busy", SelBusy, 32'h0);
    tick();
    #2 reset_n = 1'b1;
    we0 = 1'b0; set_busy = 1'b0; rs1 = 5'd10; rs2 = 5'd5;
    expect_out("rst_no_commit_r10", SelA, 32'h0);
    expect_out("rst_cleared_r5", SelB, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised integer register file for the RV32I core, replacing the single-write-port file. Two registered read ports, two write ports (port 0: ALU writeback, port 1: load writeback), a per-register busy scoreboard for hazard detection, a read-hold (stall) input, and optional write-to-read bypass. It sits between decode (reads, busy marking) and writeback (writes, busy clearing).

## Interface
- `XLEN`, default 32: register data width.
- `NREGS`, default 32: number of registers; power of two, ≥ 2. Address width `AW = $clog2(NREGS)` is a derived localparam.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `rd_en`  in  1: when 1, read outputs update at the edge; when 0, read outputs hold (stall).
- `rs1`, `rs2`  in  AW each: read addresses.
- `a`, `b`  out  XLEN each: registered read data for `rs1` / `rs2`.
- `a_busy`, `b_busy`  out  1 each: registered busy status for `rs1` / `rs2`.
- `we0`, `we1`  in  1 each: write enables.
- `wa0`, `wa1`  in  AW each: write addresses.
- `wd0`, `wd1`  in  XLEN each: write data.
- `set_busy`  in  1: marks register `set_addr` as having an in-flight producer.
- `set_addr`  in  AW: register to mark.
- `busy`  out  NREGS: current scoreboard vector; bit 0 is always 0.

## Operation
- Register 0 is hardwired to zero:
  - Writes to address 0 are dropped on both ports.
  - Reads of address 0 return 0.
  - `set_busy` to address 0 is ignored, so `busy[0]` stays 0.
- Writes:
  - Each enabled port with a nonzero address updates its register at the edge.
  - If both ports write the same address in the same cycle, port 1 (load) wins. Ports to different addresses both commit.
- Scoreboard, per register r, at each edge:
  - The bit is cleared when any enabled write targets r.
  - The bit is set when `set_busy` targets r.
  - If set and clear hit r in the same cycle, set wins: a new producer was issued.
- Reads (when `rd_en`=1), with `REGFILE_BYPASS_EN` defined:
  - `a` takes the post-edge value of `rs1`: `wd1` if port 1 writes `rs1` this cycle, else `wd0` if port 0 writes `rs1`, else the stored value.
  - `a_busy` takes the post-edge busy bit of `rs1`.
  - `b` / `b_busy` follow the same rules for `rs2`.
- Reads without `REGFILE_BYPASS_EN`:
  - `a` / `b` take the pre-edge stored values.
  - `a_busy` / `b_busy` take the pre-edge busy bits.
- Stall: when `rd_en`=0, `a`, `b`, `a_busy` and `b_busy` hold their values. Writes and scoreboard updates proceed regardless of `rd_en`.
- Reset (`reset_n`=0, asynchronous, also mid-operation):
  - All registers, `busy`, `a`, `b`, `a_busy` and `b_busy` go to 0 immediately.
  - No write commits while reset is asserted.
  - Normal operation resumes at the first rising edge after deassertion.

## Timing
- Read latency is 1 cycle: address presented in cycle N, data on `a` / `b` after edge N.
- Write-to-array latency is 1 cycle: data is stored at edge N and readable from the array in cycle N+1.
- Write-to-read through the same edge: visible with bypass; the old value without it.
- `busy` is a direct register output. It reflects `set_busy` / writes of cycle N after edge N.
- Outputs are registered only: no combinational path from inputs to outputs.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Same-cycle write data is forwarded to the read outputs.
  - Same-cycle set/clear is reflected in `a_busy` / `b_busy`.
  - Used when decode and writeback share a cycle.
- `REGFILE_BYPASS_EN` undefined:
  - Read outputs see pre-edge array and scoreboard state.
  - The pipeline must resolve the one-cycle window externally.

## Test plan
- Reset, then read: hold `reset_n`=0, then release; `rs1`=5, `rs2`=31, `rd_en`=1 → `a`=0, `b`=0, `busy`=0. Assert `reset_n` mid-cycle after writes → all outputs 0 before the next edge.
- Write then read, with x0: `we0`=1, `wa0`=5, `wd0`=0xDEADBEEF; next cycle `rs1`=5 → `a`=0xDEADBEEF. Write 0x1234 to address 0 via `we1`, then read `rs2`=0 → `b`=0.
- Dual-write conflict: `we0`/`wa0`=7/`wd0`=0x11 and `we1`/`wa1`=7/`wd1`=0x22 in one cycle → register 7 reads 0x22. Same stimulus with `wa0`=8 → reg 7=0x22, reg 8=0x11.
- Bypass: `wa1`=9, `wd1`=0xA5A5A5A5 with `rs1`=9 in the same cycle:
  - With `REGFILE_BYPASS_EN`, `a`=0xA5A5A5A5 after the edge.
  - Without it, `a` shows the old value of 9; 0xA5A5A5A5 one cycle later.
- Scoreboard:
  - `set_busy`/`set_addr`=3 → `busy[3]`=1, then `rs1`=3 → `a_busy`=1.
  - `we0` to 3 → `busy[3]`=0.
  - `set_busy` to 3 together with `we1` to 3 → `busy[3]` stays 1.
  - `set_addr`=0 → `busy[0]`=0.
- Stall: latch `a`=0xDEADBEEF, drop `rd_en`, change `rs1` and write reg 5=0x55 → `a` holds 0xDEADBEEF. Raise `rd_en` with `rs1`=5 → `a`=0x55.
